// File: rtl/uart_tx_fifo.sv
// Transmit byte FIFO feeding a UART holding register: valid/ready push side,
// single-cycle write strobes on the drain side, with a status hold-off after each load.
module uart_tx_fifo #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int HOLDOFF = 2
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [7:0]    in_data,
   output logic          in_ready,
   input  logic          txempty,
   output logic [7:0]    txdata,
   output logic          write,
   output logic [AW:0]   count,
   output logic          overflow,
   input  logic          clr_overflow
);

   localparam int          HW   = $clog2(HOLDOFF + 1);
   localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

   typedef enum logic {IDLE, HOLD} state_t;

   state_t            state, state_nxt;
   logic [HW-1:0]     hold_cnt, hold_nxt;
   logic [AW-1:0]     wr_ptr, rd_ptr;
   logic [7:0]        mem [0:DEPTH-1];
   logic              push, pop;

   // No bypass: a full FIFO refuses even when a pop happens the same cycle.
   assign in_ready = (count != FULL);
   assign push     = in_valid & in_ready;

   // NOTE: storage has no reset; validity is tracked solely by count, so
   // clearing the array would only cost reset routing.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= in_data;
   end

   // NOTE: combinational blocks assign every output a default first so no
   // path through the case can leave a latch behind.
   always_comb begin
      state_nxt = state;
      hold_nxt  = hold_cnt;
      pop       = 1'b0;
      case (state)
         IDLE: begin
            if (count != '0 && txempty) begin
               pop       = 1'b1;
               state_nxt = HOLD;
               hold_nxt  = HW'(HOLDOFF);
            end
         end
         HOLD: begin
            if (hold_cnt == '0)
               state_nxt = IDLE;
            else
               hold_nxt = hold_cnt - HW'(1);
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         hold_cnt <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         write    <= 1'b0;
         txdata   <= 8'h00;
         overflow <= 1'b0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_nxt;
         write    <= pop;
         if (pop) begin
            txdata <= mem[rd_ptr];
            rd_ptr <= rd_ptr + AW'(1);
         end
         if (push)
            wr_ptr <= wr_ptr + AW'(1);
         case ({push, pop})
            2'b10:   count <= count + (AW + 1)'(1);
            2'b01:   count <= count - (AW + 1)'(1);
            default: count <= count;
         endcase
         // Set has priority over clear.
         if (in_valid && !in_ready)
            overflow <= 1'b1;
         else if (clr_overflow)
            overflow <= 1'b0;
      end
   end

endmodule
